// File: rtl/bp_update_ctrl.sv
// Branch predictor update scheduler: flags mispredictions from resolution events and queues
// BTB/BHT updates, draining them through the table port shared with fetch.
module bp_update_ctrl #(
   parameter int PC_W        = 32,
   parameter int BTB_ENTRIES = 32,
   parameter int IDX_W       = 5,
   parameter int Q_DEPTH     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             res_valid,
   output logic             res_ready,
   input  logic [PC_W-1:0]  res_pc,
   input  logic [PC_W-1:0]  res_target,
   input  logic             res_taken,
   input  logic             res_hit,
   input  logic [IDX_W-1:0] res_hit_idx,
   input  logic [1:0]       res_ctr,
   input  logic [PC_W-1:0]  res_pred_tgt,
   input  logic             fetch_lookup,
   output logic             stall_fetch,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic             tbl_we,
   output logic [IDX_W-1:0] tbl_idx,
   output logic [PC_W-1:0]  tbl_tag,
   output logic [PC_W-1:0]  tbl_target,
   output logic [1:0]       tbl_ctr
);

   localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [PC_W-1:0]  tag;
      logic [PC_W-1:0]  target;
      logic [1:0]       ctr;
   } upd_t;

   upd_t             q_mem [Q_DEPTH];
   logic [PTR_W-1:0] head_reg, tail_reg;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [IDX_W-1:0] rr_ptr_reg;
   state_t           state_reg, state_next;

   logic pred_t, mispredict, accept, enq, deq;
   upd_t enq_entry;
   logic [1:0] ctr_upd;

   assign res_ready   = (count_reg < CNT_W'(Q_DEPTH));
   assign stall_fetch = (state_reg == FORCE);

   assign pred_t     = res_hit & res_ctr[1];
   assign mispredict = (pred_t != res_taken) |
                       (pred_t & res_taken & (res_pred_tgt != res_target));
   assign accept     = res_valid & res_ready;
   // A not-taken miss leaves the tables untouched; only hits and taken misses update.
   assign enq        = accept & (res_hit | res_taken);
   assign deq        = (count_reg != '0) & (~fetch_lookup | (state_reg == FORCE));

   always_comb begin
      ctr_upd = res_ctr;
      if (res_taken) begin
         if (res_ctr != 2'b11) ctr_upd = res_ctr + 2'd1;
      end else begin
         if (res_ctr != 2'b00) ctr_upd = res_ctr - 2'd1;
      end
   end

   always_comb begin
      enq_entry.tag    = res_pc;
      enq_entry.idx    = res_hit ? res_hit_idx : rr_ptr_reg;
      enq_entry.ctr    = res_hit ? ctr_upd : 2'b10;
      enq_entry.target = (res_hit & ~res_taken) ? res_pred_tgt : res_target;
   end

   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // FORCE releases only at Q_DEPTH-2 so fetch is not stalled and released on alternate cycles.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (count_next != '0) state_next = DRAIN;
         DRAIN: begin
            if (count_next == '0)                     state_next = IDLE;
            else if (count_next == CNT_W'(Q_DEPTH))   state_next = FORCE;
         end
         FORCE: begin
            if (count_next == '0)                          state_next = IDLE;
            else if (count_next <= CNT_W'(Q_DEPTH - 2))    state_next = DRAIN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (enq) q_mem[tail_reg] <= enq_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg    <= '0;
         tail_reg    <= '0;
         count_reg   <= '0;
         rr_ptr_reg  <= '0;
         state_reg   <= IDLE;
         flush       <= 1'b0;
         redirect_pc <= '0;
         tbl_we      <= 1'b0;
         tbl_idx     <= '0;
         tbl_tag     <= '0;
         tbl_target  <= '0;
         tbl_ctr     <= '0;
      end else begin
         count_reg <= count_next;
         state_reg <= state_next;
         if (enq) tail_reg <= (tail_reg == PTR_W'(Q_DEPTH - 1)) ? '0 : tail_reg + PTR_W'(1);
         if (deq) head_reg <= (head_reg == PTR_W'(Q_DEPTH - 1)) ? '0 : head_reg + PTR_W'(1);
         if (enq & ~res_hit)
            rr_ptr_reg <= (rr_ptr_reg == IDX_W'(BTB_ENTRIES - 1)) ? '0 : rr_ptr_reg + IDX_W'(1);
         flush <= accept & mispredict;
         if (accept) redirect_pc <= res_taken ? res_target : res_pc + PC_W'(4);
         tbl_we <= deq;
         if (deq) begin
            tbl_idx    <= q_mem[head_reg].idx;
            tbl_tag    <= q_mem[head_reg].tag;
            tbl_target <= q_mem[head_reg].target;
            tbl_ctr    <= q_mem[head_reg].ctr;
         end
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: a queue-based reference model predicts writes, flushes
// and stalls; a negedge monitor compares them against the DUT.
module tb_bp_update_ctrl;
   localparam int PC_W = 32, BTB_ENTRIES = 32, IDX_W = 5, QD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic res_valid = 1'b0, res_ready;
   logic [PC_W-1:0] res_pc = '0, res_target = '0, res_pred_tgt = '0;
   logic res_taken = 1'b0, res_hit = 1'b0;
   logic [IDX_W-1:0] res_hit_idx = '0;
   logic [1:0] res_ctr = '0;
   logic fetch_lookup = 1'b0;
   logic stall_fetch, flush, tbl_we;
   logic [PC_W-1:0] redirect_pc, tbl_tag, tbl_target;
   logic [IDX_W-1:0] tbl_idx;
   logic [1:0] tbl_ctr;

   bp_update_ctrl #(.PC_W(PC_W), .BTB_ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W), .Q_DEPTH(QD)) dut (
      .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(res_ready),
      .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken), .res_hit(res_hit),
      .res_hit_idx(res_hit_idx), .res_ctr(res_ctr), .res_pred_tgt(res_pred_tgt),
      .fetch_lookup(fetch_lookup), .stall_fetch(stall_fetch), .flush(flush),
      .redirect_pc(redirect_pc), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_tag(tbl_tag),
      .tbl_target(tbl_target), .tbl_ctr(tbl_ctr));

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [31:0] tag;
      logic [31:0] target;
      logic [1:0]  ctr;
   } ent_t;

   ent_t        mq[$];      // pending updates, oldest first
   ent_t        wr_q[$];    // writes the DUT should present now
   logic [31:0] redir_q[$]; // redirect targets of expected flushes
   int  rr = 0;
   bit  forcing = 0, exp_we = 0, exp_flush = 0;
   int  n_vec = 0, n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end else
         $display("ok   %s = %0h t=%0t", name, act, $time);
   endtask

   // Reference model: updates are a list; the port goes to the list head whenever fetch does
   // not claim it, or always while the list has recently been full.
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete(); wr_q.delete(); redir_q.delete();
         rr = 0; forcing = 0; exp_we = 0; exp_flush = 0;
      end else begin
         bit   take_port, acc, pt, mis;
         ent_t e;
         int   nc;
         take_port = (mq.size() > 0) && (!fetch_lookup || forcing);
         acc       = res_valid && (mq.size() < QD);
         exp_we    = take_port;
         if (take_port) begin
            wr_q.push_back(mq[0]);
            void'(mq.pop_front());
         end
         exp_flush = 0;
         if (acc) begin
            pt  = res_hit && (res_ctr >= 2);
            mis = (pt != res_taken) || (pt && res_taken && res_pred_tgt != res_target);
            exp_flush = mis;
            if (mis) redir_q.push_back(res_taken ? res_target : res_pc + 32'd4);
            if (res_hit) begin
               nc = res_taken ? ((res_ctr == 3) ? 3 : res_ctr + 1)
                              : ((res_ctr == 0) ? 0 : res_ctr - 1);
               e.idx = res_hit_idx; e.ctr = 2'(nc);
               e.target = res_taken ? res_target : res_pred_tgt;
               e.tag = res_pc;
               mq.push_back(e);
            end else if (res_taken) begin
               e.idx = rr; e.ctr = 2'b10; e.target = res_target; e.tag = res_pc;
               mq.push_back(e);
               rr = (rr + 1) % BTB_ENTRIES;
            end
         end
         if (mq.size() == QD) forcing = 1;
         else if (mq.size() <= QD - 2) forcing = 0;
      end
   end

   always @(negedge clk) begin
      ent_t w;
      logic [31:0] r;
      chk("res_ready", res_ready, mq.size() < QD);
      chk("stall_fetch", stall_fetch, forcing);
      chk("tbl_we", tbl_we, exp_we);
      if (tbl_we && wr_q.size() > 0) begin
         w = wr_q.pop_front();
         chk("tbl_idx", tbl_idx, w.idx);
         chk("tbl_tag", tbl_tag, w.tag);
         chk("tbl_target", tbl_target, w.target);
         chk("tbl_ctr", tbl_ctr, w.ctr);
      end
      chk("flush", flush, exp_flush);
      if (flush && redir_q.size() > 0) begin
         r = redir_q.pop_front();
         chk("redirect_pc", redirect_pc, r);
      end
   end

   task automatic send(input bit v, input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                       input bit hit, input logic [4:0] idx, input logic [1:0] ctr,
                       input logic [31:0] ptg, input bit fl);
      @(negedge clk);
      res_valid = v; res_pc = pc; res_target = tgt; res_taken = tk; res_hit = hit;
      res_hit_idx = idx; res_ctr = ctr; res_pred_tgt = ptg; fetch_lookup = fl;
   endtask

   task automatic idle(input int n, input bit fl);
      for (int i = 0; i < n; i++) send(0, 0, 0, 0, 0, 0, 0, 0, fl);
   endtask

   initial begin
      logic [31:0] pc, tgt;
      bit fl_bias;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // taken miss allocates idx 0, then hit saturate, then hit mispredicted not-taken
      send(1, 32'h10, 32'h24, 1, 0, 0, 2'b00, 32'h0, 0);
      send(1, 32'h14, 32'h24, 1, 1, 3, 2'b11, 32'h24, 0);
      send(1, 32'h20, 32'h50, 0, 1, 3, 2'b10, 32'h24, 0);
      idle(3, 0);
      // fetch holds the port: queue fills, FORCE drains, hysteresis release
      for (int i = 0; i < 4; i++) send(1, 32'h100 + 32'(i * 4), 32'h200 + 32'(i), 1, 0, 0, 0, 0, 1);
      idle(5, 1);
      idle(4, 0);
      // 33 taken misses wrap the allocation pointer; then a not-taken miss
      for (int i = 0; i < 33; i++) send(1, 32'h1000 + 32'(i * 4), 32'h3000 + 32'(i * 8), 1, 0, 0, 0, 0, 0);
      send(1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0);
      idle(4, 0);
      // reset mid-drain with three updates pending
      for (int i = 0; i < 3; i++) send(1, 32'h500 + 32'(i * 4), 32'h600, 1, 0, 0, 0, 0, 1);
      send(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_tbl_we", tbl_we, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_res_ready", res_ready, 1'b1);
      chk("rst_stall", stall_fetch, 1'b0);
      idle(2, 0);
      rst_n = 1'b1;
      // randomized traffic with phases of heavy and light fetch pressure
      for (int i = 0; i < 400; i++) begin
         fl_bias = ((i / 50) % 2) == 1;
         pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         tgt = $urandom & 32'hFFFF_FFFC;
         send($urandom_range(0, 9) < 7, pc, tgt, 1'($urandom), 1'($urandom),
              5'($urandom), 2'($urandom),
              ($urandom_range(0, 1) == 1) ? tgt : ($urandom & 32'hFFFF_FFFC),
              fl_bias ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3));
      end
      idle(10, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
